vscpu_bus_bridge: RTL and testbench



---
 rtl/vscpu_pkg.sv | 21 ++
 rtl/vscpu_bus_bridge_if.sv | 33 +++
 rtl/vscpu_fifo.sv | 52 +++++
 rtl/vscpu_bus_bridge.sv | 114 +++++++++++
 tb/tb_vscpu_bus_bridge.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vscpu_pkg.sv
// Shared constants for the VSCPU bus bridge: bus widths, MMIO map, STATUS bits.
package vscpu_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    // MMIO window occupies the top 16 words of the address space
    localparam logic [ADDR_W-1:0] MMIO_BASE   = 14'h3FF0;
    localparam logic [ADDR_W-1:0] ADDR_TXDATA = 14'h3FF0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 14'h3FF1;
    localparam logic [ADDR_W-1:0] ADDR_RXDATA = 14'h3FF2;
    localparam logic [ADDR_W-1:0] ADDR_CYCLES = 14'h3FF3;

    // STATUS register bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_HELD  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_TX_CNT   = 4;   // tx_count lives at [ST_TX_CNT +: count width]

endpackage

// File: rtl/vscpu_bus_bridge_if.sv
// Bus bundle between CPU, RAM and console streams. The bridge takes the slave view.
interface vscpu_bus_bridge_if import vscpu_pkg::*; #(parameter int SIZE = ADDR_W);

    // CPU side
    logic              wrEn;
    logic [SIZE-1:0]   addr_toRam;
    logic [DATA_W-1:0] data_toRam;
    logic [DATA_W-1:0] data_fromRam;
    // RAM side
    logic              ram_wrEn;
    logic [SIZE-1:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    // console output stream
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    // console input stream
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;

    modport slave (
        input  wrEn, addr_toRam, data_toRam, ram_rdata, tx_ready, rx_valid, rx_data,
        output data_fromRam, ram_wrEn, ram_addr, ram_wdata, tx_valid, tx_data, rx_ready
    );

    modport master (
        output wrEn, addr_toRam, data_toRam, ram_rdata, tx_ready, rx_valid, rx_data,
        input  data_fromRam, ram_wrEn, ram_addr, ram_wdata, tx_valid, tx_data, rx_ready
    );

endinterface

// File: rtl/vscpu_fifo.sv
// Small synchronous FIFO with occupancy count; simultaneous push+pop allowed when full.
module vscpu_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,                  // power of two
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    // a pop frees the slot the same cycle, so a full queue can still take a push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // storage, pointers (natural power-of-two wrap) and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vscpu_bus_bridge.sv
// CPU-to-RAM bridge with a small MMIO window: TX queue, RX holding register, cycle counter.
module vscpu_bus_bridge import vscpu_pkg::*; #(
    parameter int SIZE     = 14,
    parameter int TX_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    vscpu_bus_bridge_if.slave        bus
);

    localparam int CNT_W = $clog2(TX_DEPTH + 1);

    logic              is_ram;
    logic              wr_tx, wr_st, wr_rx;
    logic              tx_full, tx_empty, tx_pop, tx_push;
    logic [CNT_W-1:0]  tx_count;
    logic              tx_ovf;
    logic              rx_held;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] cycles;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] mmio_rd;
    logic              sel_ram;
    logic [DATA_W-1:0] rd_word;

    assign is_ram = (bus.addr_toRam < SIZE'(MMIO_BASE));
    assign wr_tx  = bus.wrEn && (bus.addr_toRam == SIZE'(ADDR_TXDATA));
    assign wr_st  = bus.wrEn && (bus.addr_toRam == SIZE'(ADDR_STATUS));
    assign wr_rx  = bus.wrEn && (bus.addr_toRam == SIZE'(ADDR_RXDATA));

    // RAM path is purely combinational; MMIO writes are masked off the strobe
    assign bus.ram_addr  = bus.addr_toRam;
    assign bus.ram_wdata = bus.data_toRam;
    assign bus.ram_wrEn  = bus.wrEn && is_ram;

    assign tx_pop  = bus.tx_valid && bus.tx_ready;
    assign tx_push = wr_tx && (!tx_full || tx_pop);

    vscpu_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_txq (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (bus.data_toRam),
        .dout  (bus.tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_held;

    // sticky overflow: a dropped push in the same cycle beats the W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             tx_ovf <= 1'b0;
        else if (wr_tx && !tx_push)          tx_ovf <= 1'b1;
        else if (wr_st && bus.data_toRam[ST_TX_OVF]) tx_ovf <= 1'b0;
    end

    // single-entry RX holder; rx_ready is low while held, so pop and capture never coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_held <= 1'b0;
            rx_word <= '0;
        end else if (wr_rx && rx_held) begin
            rx_held <= 1'b0;
        end else if (bus.rx_valid && bus.rx_ready) begin
            rx_held <= 1'b1;
            rx_word <= bus.rx_data;
        end
    end

    // free-running cycle counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycles <= '0;
        else     cycles <= cycles + 1'b1;
    end

    // STATUS word assembly
    always_comb begin
        status                       = '0;
        status[ST_TX_FULL]           = tx_full;
        status[ST_TX_EMPTY]          = tx_empty;
        status[ST_RX_HELD]           = rx_held;
        status[ST_TX_OVF]            = tx_ovf;
        status[ST_TX_CNT +: CNT_W]   = tx_count;
    end

    // MMIO read decode; write-only and reserved addresses read 0
    always_comb begin
        mmio_rd = '0;
        case (bus.addr_toRam)
            SIZE'(ADDR_STATUS): mmio_rd = status;
            SIZE'(ADDR_RXDATA): mmio_rd = rx_word;
            SIZE'(ADDR_CYCLES): mmio_rd = cycles;
            default:            mmio_rd = '0;
        endcase
    end

    // register region select and MMIO word so every region has one-cycle read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ram <= 1'b1;
            rd_word <= '0;
        end else begin
            sel_ram <= is_ram;
            rd_word <= mmio_rd;
        end
    end

    assign bus.data_fromRam = sel_ram ? bus.ram_rdata : rd_word;

endmodule

// File: tb/tb_vscpu_bus_bridge.sv
// Directed bench for vscpu_bus_bridge: RAM path, TX queue, RX holder, CYCLES, reset.
module tb_vscpu_bus_bridge;
    import vscpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vscpu_bus_bridge_if #(.SIZE(14)) bus();

    vscpu_bus_bridge #(.SIZE(14), .TX_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model with one-cycle registered read
    logic [31:0] ram [0:16383];
    always @(posedge clk) begin
        if (bus.ram_wrEn) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one write cycle starting at a negedge, ends at the next negedge
    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        bus.wrEn       = 1'b1;
        bus.addr_toRam = a;
        bus.data_toRam = d;
        @(negedge clk);
        bus.wrEn       = 1'b0;
    endtask

    // present address at a negedge, sample returned word one cycle later
    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        bus.wrEn       = 1'b0;
        bus.addr_toRam = a;
        @(negedge clk);
        d = bus.data_fromRam;
    endtask

    initial begin
        logic [31:0] v, c1, c2;
        bus.wrEn = 1'b0; bus.addr_toRam = '0; bus.data_toRam = '0;
        bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;

        // reset state
        #12;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        bus.wrEn = 1'b1; bus.addr_toRam = 14'h0007;
        #1 chk("rst_ram_wrEn", 32'(bus.ram_wrEn), 32'h1);
        bus.wrEn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(ADDR_STATUS, v); chk("status_after_rst", v, 32'h02);

        // RAM write/read
        bus.wrEn = 1'b1; bus.addr_toRam = 14'h0005; bus.data_toRam = 32'h12345678;
        #1;
        chk("ram_wrEn_pulse", 32'(bus.ram_wrEn), 32'h1);
        chk("ram_addr", 32'(bus.ram_addr), 32'h5);
        chk("ram_wdata", bus.ram_wdata, 32'h12345678);
        @(negedge clk); bus.wrEn = 1'b0;
        #1 chk("ram_wrEn_low", 32'(bus.ram_wrEn), 32'h0);
        rd(14'h0005, v); chk("ram_read_5", v, 32'h12345678);

        // last RAM word vs first MMIO word
        bus.wrEn = 1'b1; bus.addr_toRam = 14'h3FEF; bus.data_toRam = 32'hDEADBEEF;
        #1 chk("ram_wrEn_3FEF", 32'(bus.ram_wrEn), 32'h1);
        @(negedge clk); bus.wrEn = 1'b0;
        bus.wrEn = 1'b1; bus.addr_toRam = ADDR_STATUS; bus.data_toRam = 32'h0;
        #1 chk("ram_wrEn_mmio", 32'(bus.ram_wrEn), 32'h0);
        @(negedge clk); bus.wrEn = 1'b0;
        rd(14'h3FEF, v); chk("ram_read_3FEF", v, 32'hDEADBEEF);
        rd(14'h3FF4, v); chk("reserved_3FF4", v, 32'h0);
        rd(14'h3FFF, v); chk("reserved_3FFF", v, 32'h0);

        // TX overflow with tx_ready low
        for (int i = 0; i < 5; i++) wr(ADDR_TXDATA, 32'hA0 + 32'(i));
        chk("tx_valid_full", 32'(bus.tx_valid), 32'h1);
        chk("tx_head_A0", bus.tx_data, 32'hA0);
        rd(ADDR_STATUS, v); chk("status_full_ovf", v, 32'h49);
        wr(ADDR_STATUS, 32'h0);
        rd(ADDR_STATUS, v); chk("status_w0_keeps", v, 32'h49);
        wr(ADDR_STATUS, 32'h8);
        rd(ADDR_STATUS, v); chk("status_ovf_clr", v, 32'h41);

        // push into full FIFO while popping, then drain in order
        bus.tx_ready = 1'b1;
        wr(ADDR_TXDATA, 32'hA5);
        chk("drain_1", bus.tx_data, 32'hA1);
        @(negedge clk); chk("drain_2", bus.tx_data, 32'hA2);
        @(negedge clk); chk("drain_3", bus.tx_data, 32'hA3);
        @(negedge clk); chk("drain_4", bus.tx_data, 32'hA5);
        @(negedge clk); chk("drained_valid", 32'(bus.tx_valid), 32'h0);
        bus.tx_ready = 1'b0;
        rd(ADDR_STATUS, v); chk("status_no_ovf", v, 32'h02);

        // RX holding register
        bus.rx_valid = 1'b1; bus.rx_data = 32'hCAFE;
        @(negedge clk);
        chk("rx_ready_low", 32'(bus.rx_ready), 32'h0);
        bus.rx_data = 32'hBEEF;
        rd(ADDR_RXDATA, v); chk("rx_read_1", v, 32'hCAFE);
        rd(ADDR_RXDATA, v); chk("rx_read_2", v, 32'hCAFE);
        rd(ADDR_STATUS, v); chk("status_rx_held", v, 32'h06);
        wr(ADDR_RXDATA, 32'h0);
        chk("rx_ready_after_pop", 32'(bus.rx_ready), 32'h1);
        @(negedge clk);
        chk("rx_ready_recapture", 32'(bus.rx_ready), 32'h0);
        bus.rx_valid = 1'b0;
        rd(ADDR_RXDATA, v); chk("rx_read_next", v, 32'hBEEF);
        wr(ADDR_RXDATA, 32'h0);
        wr(ADDR_RXDATA, 32'h0);
        chk("rx_pop_empty", 32'(bus.rx_ready), 32'h1);
        rd(ADDR_STATUS, v); chk("status_rx_clear", v, 32'h02);

        // CYCLES counter: delta and wrap
        bus.addr_toRam = ADDR_CYCLES;
        @(negedge clk); c1 = bus.data_fromRam;
        repeat (10) @(negedge clk);
        c2 = bus.data_fromRam;
        chk("cycles_delta", c2 - c1, 32'd10);
        force dut.cycles = 32'hFFFF_FFFF;
        #1 release dut.cycles;
        @(negedge clk); chk("cycles_max", bus.data_fromRam, 32'hFFFF_FFFF);
        @(negedge clk); chk("cycles_wrap", bus.data_fromRam, 32'h0);

        // asynchronous reset with TX words queued and an RX word held
        for (int i = 0; i < 3; i++) wr(ADDR_TXDATA, 32'hB0 + 32'(i));
        bus.rx_valid = 1'b1; bus.rx_data = 32'h1234;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'h1);
        chk("pre_rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("async_rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        @(negedge clk); rst = 1'b0;
        rd(ADDR_STATUS, v); chk("status_post_rst", v, 32'h02);
        chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
